// File: rtl/kleine_pkg.sv
// Shared types and constants for the kleine core front end.
package kleine_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous power-of-two FIFO with extra-bit wrap pointers and a flush.
// A push is accepted when full only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (count_o == CNT_W'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign push_ok = push_i && (!full || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage with a prefetch queue and a latency-tolerant request port.
// Queue space is reserved at request time so responses are always accepted.
module fetch_prefetch
  import kleine_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR    = 32'h8000_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [31:0] branch_vector,
  input  logic        trap,
  input  logic        mret,
  input  logic [31:0] trap_vector,
  input  logic [31:0] mret_vector,
  input  logic        stall,
  input  logic        invalidate,
  output logic        fetch_req_valid,
  input  logic        fetch_req_ready,
  output logic [31:0] fetch_address,
  input  logic        fetch_resp_valid,
  input  logic [31:0] fetch_resp_data,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic [OUT_W-1:0] drop_q, drop_d;
  fetch_entry_t     out_q, out_d;
  logic             valid_q, valid_d;

  logic             redirect;
  logic [XLEN-1:0]  target;
  logic             req_fire;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] occupancy;
  fetch_entry_t     push_entry;
  logic [$bits(fetch_entry_t)-1:0] fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;

  assign redirect = trap | mret | branch;
  assign target   = trap ? trap_vector : (mret ? mret_vector : branch_vector);

  // Occupancy counts both queued entries and slots reserved by in-flight requests.
  assign occupancy       = SUM_W'(fifo_count) + SUM_W'(outst_q);
  assign fetch_req_valid = !reset && !redirect
                         && (occupancy < SUM_W'(DEPTH))
                         && (outst_q < OUT_W'(MAX_OUTSTANDING));
  assign fetch_address   = req_pc_q;
  assign req_fire        = fetch_req_valid && fetch_req_ready;

  assign push = fetch_resp_valid && (drop_q == '0) && !redirect;
  assign pop  = !redirect && !stall && !invalidate && !fifo_empty;

  assign push_entry = '{pc: resp_pc_q, next_pc: resp_pc_q + STEP, instr: fetch_resp_data};

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_comb begin
    req_pc_d  = req_pc_q;
    resp_pc_d = resp_pc_q;
    drop_d    = drop_q;
    out_d     = out_q;
    valid_d   = valid_q;
    outst_d   = outst_q + OUT_W'(req_fire) - OUT_W'(fetch_resp_valid);

    if (redirect) begin
      // Everything still in flight is stale; one arriving now is already discarded.
      req_pc_d  = target;
      resp_pc_d = target;
      drop_d    = outst_q - OUT_W'(fetch_resp_valid);
      valid_d   = 1'b0;
    end else begin
      if (req_fire) req_pc_d = req_pc_q + STEP;
      if (push) resp_pc_d = resp_pc_q + STEP;
      if (fetch_resp_valid && (drop_q != '0)) drop_d = drop_q - OUT_W'(1);
      if (!stall) begin
        if (pop) begin
          out_d   = fetch_entry_t'(fifo_rdata);
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc_q  <= RESET_VECTOR;
      resp_pc_q <= RESET_VECTOR;
      outst_q   <= '0;
      drop_q    <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      req_pc_q  <= req_pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
    end
  end

  assign pc_out          = out_q.pc;
  assign next_pc_out     = out_q.next_pc;
  assign instruction_out = out_q.instr;
  assign valid_out       = valid_q;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: in-order bus model with random
// latency and a transaction-level model tracking requests by redirect epoch.
module tb_fetch_prefetch;

  localparam logic [31:0] RV    = 32'h8000_0000;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch = 1'b0, trap = 1'b0, mret = 1'b0;
  logic [31:0] branch_vector = '0, trap_vector = '0, mret_vector = '0;
  logic        stall = 1'b0, invalidate = 1'b0;
  logic        fetch_req_valid, fetch_req_ready = 1'b0;
  logic [31:0] fetch_address;
  logic        fetch_resp_valid = 1'b0;
  logic [31:0] fetch_resp_data = '0;
  logic [31:0] pc_out, next_pc_out, instruction_out;
  logic        valid_out;

  fetch_prefetch #(.RESET_VECTOR(RV), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .branch(branch), .branch_vector(branch_vector),
    .trap(trap), .mret(mret), .trap_vector(trap_vector), .mret_vector(mret_vector),
    .stall(stall), .invalidate(invalidate),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_address(fetch_address),
    .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data),
    .pc_out(pc_out), .next_pc_out(next_pc_out), .instruction_out(instruction_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } bus_t;

  bus_t        bus_q[$];
  logic [31:0] mq[$];
  int          tests = 0, fails = 0, cyc = 0, epoch = 0, last_due = 0;
  logic [31:0] m_req_pc = RV, e_pc = '0, e_npc = '0, e_instr = '0;
  logic        e_valid = 1'b0;

  logic        k_rst = 1'b1, k_stall = 1'b0, k_inv = 1'b0;
  logic        k_trap = 1'b0, k_mret = 1'b0, k_branch = 1'b0;
  logic [31:0] k_tv = '0, k_mv = '0, k_bv = '0;
  int          k_lmin = 1, k_lmax = 1, k_rdy = 100;
  int          first_fire = -1, first_valid = -1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: check outputs, apply inputs, check request port, advance model.
  task automatic step();
    logic        redir, rv, fire, keep, exp_rv;
    logic [31:0] tgt;
    int          outst, lat, due;
    bus_t        b;
    @(negedge clk);
    check("valid_out", 32'(valid_out), 32'(e_valid));
    check("pc_out", pc_out, e_pc);
    check("next_pc_out", next_pc_out, e_npc);
    check("instruction_out", instruction_out, e_instr);
    if (valid_out === 1'b1 && first_valid < 0) first_valid = cyc;

    redir = !k_rst && (k_trap || k_mret || k_branch);
    tgt   = k_trap ? k_tv : (k_mret ? k_mv : k_bv);
    rv    = !k_rst && (bus_q.size() > 0) && (bus_q[0].due <= cyc);
    reset = k_rst; stall = k_stall; invalidate = k_inv;
    trap = k_trap; mret = k_mret; branch = k_branch;
    trap_vector = k_tv; mret_vector = k_mv; branch_vector = k_bv;
    fetch_req_ready  = ($urandom_range(99) < k_rdy);
    fetch_resp_valid = rv;
    fetch_resp_data  = rv ? memf(bus_q[0].addr) : $urandom();
    #1;
    outst  = bus_q.size();
    exp_rv = !k_rst && !redir && (mq.size() + outst < DEPTH) && (outst < MAXO);
    check("fetch_req_valid", 32'(fetch_req_valid), 32'(exp_rv));
    if (exp_rv) check("fetch_address", fetch_address, m_req_pc);
    fire = exp_rv && fetch_req_ready;
    if (fire && first_fire < 0) first_fire = cyc;

    if (k_rst) begin
      bus_q.delete(); mq.delete();
      e_valid = 1'b0; e_pc = '0; e_npc = '0; e_instr = '0;
      m_req_pc = RV; epoch++; last_due = 0;
    end else begin
      keep = 1'b0;
      if (rv) begin
        b = bus_q.pop_front();
        keep = (b.epoch == epoch) && !redir;
      end
      if (redir) begin
        mq.delete(); e_valid = 1'b0; m_req_pc = tgt; epoch++;
      end else begin
        if (!k_stall) begin
          if (k_inv || mq.size() == 0) e_valid = 1'b0;
          else begin
            e_pc = mq.pop_front(); e_npc = e_pc + 32'd4; e_instr = memf(e_pc); e_valid = 1'b1;
          end
        end
        if (keep) mq.push_back(b.addr);
        if (fire) begin
          lat = $urandom_range(k_lmax, k_lmin);
          due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
          last_due = due;
          bus_q.push_back('{m_req_pc, epoch, due});
          m_req_pc = m_req_pc + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    int          n, bad;
    logic [31:0] seen_pc;
    repeat (2) @(posedge clk);

    // Reset, then free-running k=1 fetch.
    k_rst = 1'b1; repeat (2) step();
    k_rst = 1'b0; k_lmin = 1; k_lmax = 1; k_rdy = 100;
    repeat (6) step();
    n = 0;
    repeat (8) begin step(); n += int'(valid_out); end
    check("first_valid_latency", 32'(first_valid), 32'(first_fire + 3));
    check("throughput_k1", 32'(n), 32'd8);

    // Long stall: queue fills, outputs freeze, then drain without gaps.
    k_stall = 1'b1; repeat (10) step();
    k_stall = 1'b0; step();
    n = 0;
    repeat (4) begin step(); n += int'(valid_out); end
    check("stall_release_run", 32'(n), 32'd4);

    // Branch with two requests outstanding.
    k_lmin = 3; k_lmax = 3;
    n = 0;
    while (bus_q.size() != MAXO && n < 20) begin step(); n++; end
    check("wait_outstanding", 32'(bus_q.size()), 32'(MAXO));
    k_branch = 1'b1; k_bv = 32'h0000_1000; step(); k_branch = 1'b0;
    bad = 0; seen_pc = 32'hDEAD_BEEF;
    repeat (20) begin
      step();
      if (valid_out === 1'b1) begin
        if (seen_pc == 32'hDEAD_BEEF) seen_pc = pc_out;
        if (pc_out < 32'h0000_1000 || pc_out >= 32'h0000_1100) bad++;
      end
    end
    check("branch_first_pc", seen_pc, 32'h0000_1000);
    check("branch_stale_pcs", 32'(bad), 32'd0);

    // Trap and branch together: trap wins.
    k_lmin = 1; k_lmax = 2;
    k_trap = 1'b1; k_tv = 32'h0000_0100; k_branch = 1'b1; k_bv = 32'h0000_2000;
    step();
    k_trap = 1'b0; k_branch = 1'b0;
    seen_pc = 32'hDEAD_BEEF;
    repeat (15) begin
      step();
      if (valid_out === 1'b1 && seen_pc == 32'hDEAD_BEEF) seen_pc = pc_out;
    end
    check("trap_priority_pc", seen_pc, 32'h0000_0100);

    // Random ready, latency 1-5, stalls, invalidates and redirects.
    k_lmin = 1; k_lmax = 5; k_rdy = 60;
    repeat (800) begin
      k_stall  = ($urandom_range(99) < 15);
      k_inv    = ($urandom_range(99) < 10);
      k_trap   = ($urandom_range(99) < 1);
      k_mret   = ($urandom_range(99) < 1);
      k_branch = ($urandom_range(99) < 2);
      k_tv = $urandom() & 32'hFFFF_FFFC;
      k_mv = $urandom() & 32'hFFFF_FFFC;
      k_bv = $urandom() & 32'hFFFF_FFFC;
      step();
    end
    k_stall = 1'b0; k_inv = 1'b0; k_trap = 1'b0; k_mret = 1'b0; k_branch = 1'b0;
    k_rdy = 100; k_lmin = 2; k_lmax = 2;

    // Reset mid-operation with the queue backed up and requests in flight.
    k_stall = 1'b1; repeat (8) step();
    k_rst = 1'b1; step();
    k_rst = 1'b0; k_stall = 1'b0; k_lmin = 1; k_lmax = 1;
    step();
    check("post_reset_valid", 32'(valid_out), 32'd0);
    seen_pc = 32'hDEAD_BEEF;
    repeat (10) begin
      step();
      if (valid_out === 1'b1 && seen_pc == 32'hDEAD_BEEF) seen_pc = pc_out;
    end
    check("post_reset_first_pc", seen_pc, RV);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised successor to the single-register fetch stage. It decouples instruction fetch from decode with a DEPTH-entry prefetch queue and a valid/ready request port that tolerates variable bus latency, with up to MAX_OUTSTANDING requests in flight. On any redirect (trap, mret, branch) it flushes the queue and silently drops stale in-flight responses. It sits between busio and decode, with redirect inputs from memory/writeback/csr and stall/invalidate from hazard.

## Interface
- RESET_VECTOR, 32'h8000_0000, first fetch address after reset
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- MAX_OUTSTANDING, 2, max issued-but-unanswered requests; 1..DEPTH
- clk  input  1  single clock, all state on posedge
- reset  input  1  synchronous, active-high
- branch / branch_vector  input  1/32  redirect from memory stage
- trap / mret  input  1/1  redirects from writeback
- trap_vector / mret_vector  input  32/32  targets from csr
- stall  input  1  hold decode-facing outputs
- invalidate  input  1  insert bubble instead of popping
- fetch_req_valid  output  1  request to busio
- fetch_req_ready  input  1  busio accepts request
- fetch_address  output  32  word address of request
- fetch_resp_valid  input  1  in-order response, always accepted
- fetch_resp_data  input  32  instruction word
- pc_out / next_pc_out / instruction_out  output  32 each  to decode
- valid_out  output  1  to decode

## Operation
- Redirect = trap | mret | branch. Target priority: trap > mret > branch. Reset overrides all.
- Request PC register `req_pc`:
  - Redirect loads the target.
  - An accepted request (valid & ready) adds 4.
- fetch_req_valid = !redirect && (count + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
  - This reserves queue space per request, so a response is never refused.
- Counters:
  - `outstanding`: +1 on request accept, −1 on response; both in one cycle leaves it unchanged.
  - `drop`: number of in-flight responses to discard.
- Response handling:
  - If drop > 0: discard the response and decrement drop.
  - Otherwise push {resp_pc, data, resp_pc+4} and add 4 to `resp_pc`.
  - A redirect loads `resp_pc` with the target.
- On redirect:
  - Queue is emptied.
  - drop <= outstanding − fetch_resp_valid.
  - A response arriving in the redirect cycle is discarded.
  - valid_out <= 0 regardless of stall.
- Output register, absent a redirect:
  - stall=1: hold everything.
  - stall=0, invalidate=1: valid_out <= 0, no pop.
  - stall=0, invalidate=0, queue non-empty: pop into pc_out/next_pc_out/instruction_out and set valid_out <= 1.
  - stall=0, invalidate=0, queue empty: valid_out <= 0.
- Queue: simultaneous push and pop is legal at any count, including full. No push/pop bypass.

## Timing
- Reset values:
  - req_pc = resp_pc = RESET_VECTOR.
  - count = outstanding = drop = 0.
  - valid_out = 0; pc_out = next_pc_out = instruction_out = 0.
  - fetch_req_valid = 0 while reset is high.
- Reset mid-operation clears all state; in-flight responses after reset are not dropped. Busio is reset by the same signal.
- Latency:
  - Request is accepted at edge E.
  - The response at edge E+k is visible in the queue after that edge.
  - The instruction is on the outputs after edge E+k+1 (minimum 2 cycles at k=1).
- Throughput is one instruction per cycle when MAX_OUTSTANDING ≥ k+1 and DEPTH ≥ MAX_OUTSTANDING+1.
- A redirect at edge R:
  - The first request to the target is issued in cycle R+1.
  - The output shows no stale instruction after R.
- A back-to-back redirect reloads drop from the current outstanding, so drop is never negative.
- Invariants: count + outstanding ≤ DEPTH; drop ≤ outstanding.

## Structure
- Shared package `kleine_pkg`:
  - XLEN = 32, INSTR_BYTES = 4.
  - Typedef `fetch_entry_t` = {pc, next_pc, instr}.
- Sub-module `sync_fifo` (WIDTH, DEPTH): synchronous, power-of-two depth, extra-bit wrap pointers, flush input, count output.
  - Instantiated once with WIDTH = 96.
- Counters are $clog2(DEPTH)+1 and $clog2(MAX_OUTSTANDING)+1 bits wide.

## Test plan
- Reset release, k=1 bus, no stall: requests 8000_0000, 8000_0004, ….
  - valid_out first high 2 cycles after the first accept, then every cycle with pc_out incrementing by 4.
- Hold stall=1 for 10 cycles with DEPTH=4, MAX_OUTSTANDING=2:
  - Requests stop once count+outstanding=4.
  - Outputs frozen.
  - On release, 4 queued instructions emerge in order with no gap.
- Branch to 0000_1000 while 2 requests are outstanding:
  - Both responses are dropped; no pc other than 0000_1000, 0000_1004… reaches valid_out.
- Simultaneous trap (vector 0000_0100) and branch (0000_2000): fetch restarts at 0000_0100.
- Random fetch_req_ready and latency 1–5 with invalidate pulses:
  - Output PC sequence is gap-free between redirects.
  - valid_out=0 exactly one cycle per invalidate.
  - The count+outstanding ≤ DEPTH invariant holds.
- Reset asserted with queue full and 2 in flight:
  - Next cycle valid_out=0 and count=0.
  - The first post-reset instruction fetched is from RESET_VECTOR.
